shared_timer_arbiter: RTL and testbench
=======================================

// Module: shared_timer_arbiter
// PURPOSE
//   Shares one up-counter timer between N_REQ requesters on the I2C test fabric.
//   Requesters ask for a delay of N ticks. A round-robin arbiter grants the timer
//   to one requester at a time. A small FSM clears, runs and stops the counter.
//   The granted requester gets a one-cycle done pulse when its delay expires.
// PARAMETERS
//   N_REQ    4   number of requesters (>=2)
//   WIDTH    16  delay/count width in bits
//   PRESCALE 1   clk cycles per timer tick (>=1); 1 = tick every cycle
// PORTS
//   clk    in   1            clock, rising edge
//   rst    in   1            reset, asynchronous, active-high
//   req    in   N_REQ        request level per requester; hold high until done
//   delay  in   N_REQ*WIDTH  delay per requester; slice i = [i*WIDTH +: WIDTH]
//   grant  out  N_REQ        one-hot owner of timer; all-zero when idle
//   done   out  N_REQ        one-cycle pulse to owner when its delay has expired
//   busy   out  1            high in COUNT and DONE states
//   count  out  WIDTH        current timer value (ticks elapsed for owner)
// BEHAVIOUR
//   Reset values: state=IDLE, grant=0, done=0, busy=0, count=0, prescaler=0.
//     last_owner=N_REQ-1, so requester 0 has first priority.
//   IDLE state:
//     - If any req is high, pick the first requester with req high, searching
//       from last_owner+1 upward with wrap-around (round robin).
//     - At that edge: state->COUNT; grant[sel]=1; target=delay[sel], captured
//       and held for the whole grant; count=0; prescaler=0; last_owner=sel.
//     - Otherwise stay in IDLE.
//   COUNT state:
//     - tick = (prescaler==PRESCALE-1). The prescaler wraps to 0 on tick.
//     - If count==target: state->DONE at this edge; count holds.
//     - Else if tick: count<=count+1.
//     - If req[sel] is low at an edge: abort. state->IDLE, grant=0, count=0,
//       no done pulse. last_owner keeps sel. Abort has priority over
//       count==target.
//   DONE state:
//     - done[sel]=1 and grant[sel]=1 for exactly one cycle.
//     - At the next edge: state->IDLE, grant=0, done=0, count=0.
//   Latency with PRESCALE=1 and req sampled at edge E0:
//     - grant is high from E0.
//     - done is high in the cycle after edge E(D+1), where D=delay.
//     - delay=0 gives done after E1.
//     - In general, done follows E(D*PRESCALE+1).
//   After DONE or abort, at least one IDLE cycle precedes the next grant.
//     A req that rises during COUNT/DONE is served only from IDLE.
//   A requester holding req high after its done re-enters arbitration. It gets
//     lowest priority in that round.
//   The delay input is sampled only at grant. Changing it mid-count has no effect.
//   count never wraps: it stops at target <= 2^WIDTH-1.
//   grant and done are always one-hot or zero. done is a subset of grant.
//   Asserting rst in any state returns all outputs to reset values
//     asynchronously. There is no done pulse for the interrupted requester.
// TESTING
//   1 Reset: rst high mid-COUNT -> grant=0, done=0, busy=0, count=0 immediately.
//     After release, req[2] alone is served.
//   2 Single: req[1]=1, delay[1]=3, PRESCALE=1 at E0 -> grant=4'b0010 from E0.
//     count 1,2,3 after E1..E3. done=4'b0010 after E4 only. Idle after E5.
//   3 Zero delay: req[0]=1, delay[0]=0 -> done[0] pulse after E1, busy 2 cycles.
//   4 Round robin: req=4'b1101 held, all delays=1 -> grant order 0,2,3,0,2,...
//     One IDLE cycle between grants.
//   5 Abort: req[3] drops at count=2 of delay 10 -> grant=0 next edge.
//     No done pulse. The next grant searches from requester 0.
//   6 Prescale: PRESCALE=4, delay=2 -> count increments every 4th cycle.
//     done after E9.

Source files
------------

// File: rtl/shared_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_timer_arbiter
// Description : One prescaled up-counter shared by N_REQ requesters through a
//               round-robin arbiter; the owner gets a done pulse on expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_timer_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] delay,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       count
);

  localparam int c_idx_w = $clog2(N_REQ);
  localparam int c_psc_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_psc_w-1:0] c_psc_max = c_psc_w'(PRESCALE - 1);
  localparam logic [c_idx_w:0]   c_nreq    = (c_idx_w + 1)'(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [N_REQ-1:0]     done_q, done_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     target_q, target_d;
  logic [c_psc_w-1:0]   psc_q, psc_d;
  logic [c_idx_w-1:0]   last_q, last_d;

  logic                 w_found;
  logic [c_idx_w-1:0]   w_pick;
  logic [c_idx_w:0]     w_cand;
  logic                 w_tick;

  // Round-robin search starting just after the previous owner, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = last_q;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = {1'b0, last_q} + (c_idx_w + 1)'(k);
      if (w_cand >= c_nreq) begin
        w_cand = w_cand - c_nreq;
      end
      if (!w_found && req[w_cand[c_idx_w-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[c_idx_w-1:0];
      end
    end
  end

  assign w_tick = (psc_q == c_psc_max);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    count_d  = count_q;
    target_d = target_q;
    psc_d    = psc_q;
    last_d   = last_q;
    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          state_d  = ST_COUNT;
          grant_d  = N_REQ'(1) << w_pick;
          target_d = delay[int'(w_pick)*WIDTH +: WIDTH];
          count_d  = '0;
          psc_d    = '0;
          last_d   = w_pick;
        end
      end
      ST_COUNT: begin
        // A dropped request aborts even when the target was just reached.
        if (!req[last_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          count_d = '0;
        end else begin
          psc_d = w_tick ? '0 : psc_q + 1'b1;
          if (count_q == target_q) begin
            state_d = ST_DONE;
            done_d  = grant_q;
          end else if (w_tick) begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        count_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      count_q  <= '0;
      target_q <= '0;
      psc_q    <= '0;
      last_q   <= c_idx_w'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      count_q  <= count_d;
      target_q <= target_d;
      psc_q    <= psc_d;
      last_q   <= last_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);
  assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_timer_arbiter.sv
`default_nettype none
// Bench: two timers (PRESCALE 1 and 4) share one stimulus stream; a
// transaction-level model predicts each cycle's outputs into per-DUT queues.
module tb_shared_timer_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] done;
    logic         busy;
    logic [W-1:0] count;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] delay = '0;

  logic [N-1:0] grant_a, done_a, grant_b, done_b;
  logic         busy_a, busy_b;
  logic [W-1:0] count_a, count_b;

  shared_timer_arbiter #(.N_REQ(N), .WIDTH(W), .PRESCALE(1)) u_dut_p1 (
    .clk(clk), .rst(rst), .req(req), .delay(delay),
    .grant(grant_a), .done(done_a), .busy(busy_a), .count(count_a)
  );

  shared_timer_arbiter #(.N_REQ(N), .WIDTH(W), .PRESCALE(4)) u_dut_p4 (
    .clk(clk), .rst(rst), .req(req), .delay(delay),
    .grant(grant_b), .done(done_b), .busy(busy_b), .count(count_b)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  // Model state per DUT: owner (-1 = idle), edges since grant, captured delay.
  int m_owner[2];
  int m_k[2];
  int m_d[2];
  int m_last[2];

  task automatic check(input string nm, input exp_t act, input exp_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got grant=%b done=%b busy=%b count=%0d, expected grant=%b done=%b busy=%b count=%0d",
               nm, $time, act.grant, act.done, act.busy, act.count,
               exp.grant, exp.done, exp.busy, exp.count);
    end
  endtask

  function automatic exp_t act_of(input int p);
    exp_t a;
    if (p == 0) a = {grant_a, done_a, busy_a, count_a};
    else        a = {grant_b, done_b, busy_b, count_b};
    return a;
  endfunction

  function automatic logic [N*W-1:0] dl_all(input int v);
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'(v);
    return d;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_owner[p] = -1;
      m_k[p]     = 0;
      m_d[p]     = 0;
      m_last[p]  = N - 1;
    end
  endtask

  // One clock edge: a grant lasts D*P+2 edges (COUNT for D*P+1, DONE for 1),
  // count after k edges is floor(k/P), and a low req ends the grant early.
  task automatic model_step(input int p, output exp_t e);
    int ps;
    int lim;
    ps = (p == 0) ? 1 : 4;
    if (m_owner[p] < 0) begin
      for (int j = 1; j <= N; j++) begin
        int c;
        c = (m_last[p] + j) % N;
        if (m_owner[p] < 0 && req[c]) begin
          m_owner[p] = c;
          m_k[p]     = 0;
          m_d[p]     = int'(delay[c*W +: W]);
          m_last[p]  = c;
        end
      end
    end else begin
      lim = m_d[p] * ps;
      if (m_k[p] > lim || !req[m_owner[p]]) m_owner[p] = -1;
      else m_k[p]++;
    end
    e = '0;
    if (m_owner[p] >= 0) begin
      lim     = m_d[p] * ps;
      e.grant = N'(1) << m_owner[p];
      e.busy  = 1'b1;
      e.count = W'((m_k[p] > lim) ? m_d[p] : m_k[p] / ps);
      if (m_k[p] == lim + 1) e.done = e.grant;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] dl);
    exp_t e0, e1;
    @(negedge clk);
    req   = r;
    delay = dl;
    model_step(0, e0);
    q_a.push_back(e0);
    model_step(1, e1);
    q_b.push_back(e1);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    req = '0;
    #1;
    check("async_reset_p1", act_of(0), '0);
    check("async_reset_p4", act_of(1), '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (q_a.size() > 0) check("cycle_p1", act_of(0), q_a.pop_front());
    if (q_b.size() > 0) check("cycle_p4", act_of(1), q_b.pop_front());
  end

  initial begin
    logic [N*W-1:0] dl;
    logic [N-1:0]   r;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_p1", act_of(0), '0);
    check("reset_p4", act_of(1), '0);
    rst = 1'b0;

    dl = dl_all(0);
    dl[1*W +: W] = W'(3);
    repeat (5) step(4'b0010, dl);
    repeat (3) step(4'b0000, dl);

    repeat (2) step(4'b0001, dl_all(0));
    repeat (3) step(4'b0000, dl_all(0));

    repeat (24) step(4'b1101, dl_all(1));
    repeat (3) step(4'b0000, dl_all(1));

    repeat (12) step(4'b0001, dl_all(2));
    repeat (3) step(4'b0000, dl_all(2));

    repeat (3) step(4'b1000, dl_all(10));
    repeat (4) step(4'b0001, dl_all(10));
    repeat (3) step(4'b0000, dl_all(10));

    repeat (4) step(4'b0100, dl_all(10));
    async_reset();
    repeat (4) step(4'b0100, dl_all(2));
    repeat (3) step(4'b0000, dl_all(2));

    r = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) r[i] = ($urandom_range(0, 11) != 0);
        else      r[i] = ($urandom_range(0, 3) == 0);
        dl[i*W +: W] = ($urandom_range(0, 7) == 0) ? W'($urandom_range(8, 15))
                                                   : W'($urandom_range(0, 4));
      end
      step(r, dl);
      if (n % 700 == 699) begin
        async_reset();
        r = '0;
      end
    end
    step(4'b0000, dl);

    @(posedge clk);
    #2;
    n_vec++;
    if (q_a.size() + q_b.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", q_a.size() + q_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
